dendrite_compartment: RTL
=========================

Name: dendrite_compartment

Overview:
- Counterpart of the synapse on the synapse_dendrite_if link: sums the output_current of NUM_SYN attached synapses and integrates a leaky membrane potential vmem.
- Broadcasts vmem back to every synapse, emits a one-cycle spike on threshold crossing, then holds vmem at a reset level for a refractory period.
- Operating parameters come from the same daisy-chained config_if shift chain that the synapses use.

Parameters:
- NUM_SYN, 4: number of attached synapse_dendrite_if links.
- LEAK_SHIFT, 8: right shift applied to the leak product (E_l - vmem)*g_leak.
- DT_SHIFT, 4: right shift applied to the total current before it is added to vmem.
- T_REF, 8: refractory length in clk cycles; 0 means no refractory period.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- syn[NUM_SYN]  synapse_dendrite_if.dendrite  array  reads output_current (fp::fpType, signed); drives vmem (fp::fpType, signed).
- cfg_in  config_if.slave  -  data_clk, data_in (16 bit).
- cfg_out  config_if.master  -  chain continuation.
- spike  out  1  one-cycle pulse on threshold crossing.
- vmem_out  out  16  copy of vmem, for monitoring.

Behaviour:
- Config chain, on posedge cfg_in.data_clk: E_l<=data_in; g_leak<=E_l; v_thresh<=g_leak; v_reset<=v_thresh; cfg_out.data_in<=v_reset.
- cfg_out.data_clk = cfg_in.data_clk (combinational pass-through).
- Config registers are not reset. E_l, v_thresh and v_reset are signed; g_leak is unsigned.
- Reset (asynchronous, takes effect immediately without a clock): vmem=0, spike=0, isum_q=0, state=INTEGRATE, ref_cnt=0. As a result, syn[*].vmem=0 and vmem_out=0.
- Stage 1 (registered): isum_q <= signed sum of all syn[i].output_current. Width is 16+$clog2(NUM_SYN) with sign extension, so the sum never overflows.
- Leak term (combinational from vmem):
  - ileak = ((E_l - vmem) * {1'b0,g_leak}) >>> LEAK_SHIFT.
  - Operands are a 17-bit signed difference times a 17-bit signed multiplier; the shift is arithmetic.
- Step: dv = (isum_q + ileak) >>> DT_SHIFT. vmem_next = vmem + dv, saturated to [-32768, 32767]; no wrap-around under any input.
- State machine, with transitions on posedge clk:
  - INTEGRATE, vmem_next >= v_thresh (signed compare): spike<=1, vmem<=v_reset. If T_REF>0: state<=REFRACTORY, ref_cnt<=T_REF. Otherwise stay in INTEGRATE.
  - INTEGRATE, otherwise: vmem<=vmem_next, spike<=0.
  - REFRACTORY: vmem held at v_reset, currents ignored, spike<=0, ref_cnt decrements. When ref_cnt==1: state<=INTEGRATE, ref_cnt<=0.
- Resulting refractory window: exactly T_REF cycles after the spike cycle. Integration resumes on the (T_REF+1)th edge after the spike edge.
- Latency: a change on output_current updates isum_q at edge N; it is reflected in vmem at edge N+1.
- spike and vmem=v_reset become visible on the same edge.
- Threshold reached by saturation (vmem_next=32767 with v_thresh=32767) counts as a crossing.
- Configuration changed mid-operation takes effect on the next clk edge; there is no synchronisation (config is loaded only while the network is idle).
- Reset asserted during REFRACTORY aborts the refractory period immediately.

Decomposition:
- Package fp: WORD_LENGTH=16, fpType, fpWideType, plus a new sat16 function (saturate a wide signed value to fpType).
- Sub-module dendrite_cfg_chain: the 4-register config shift chain, reusable by later compartment variants.
- The current adder tree stays inline as a generate loop.

Test Plan:
- Config load: shift 0x0001,0x0002,0x0003,0x0004 over 4 data_clk pulses -> v_reset=1, v_thresh=2, g_leak=3, E_l=4. A 5th pulse carrying 0x0005 -> cfg_out.data_in=0x0001.
- Quiescent: g_leak=0, all currents 0 -> vmem stays 0, spike never asserts over 100 cycles.
- Constant drive: each syn current=16 (sum 64), g_leak=0, v_thresh=100, v_reset=-50 -> vmem rises +4 per cycle and spikes when it reaches 100. Then vmem=-50 for 8 cycles, and the next update is -46.
- Leak: currents 0, E_l=1000, g_leak=256, vmem starting at 0 -> first step is +62. vmem rises monotonically toward 1000, never exceeds it, and never spikes with v_thresh=2000.
- Saturation: all currents 0x7FFF, v_thresh=0x7FFF -> vmem clamps at 32767, spike asserts, and no wrap to negative is ever observed.
- Async reset: assert reset mid-refractory, between clk edges -> spike=0, vmem=0, state=INTEGRATE with no clock edge required. After release, integration restarts from 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Fixed-point word types and helpers shared by the compartment and the synapse links.
package fp;

  localparam int unsigned WORD_LENGTH = 16;
  localparam int unsigned WIDE_LENGTH = 40;

  typedef logic signed [WORD_LENGTH-1:0] fpType;
  typedef logic signed [WIDE_LENGTH-1:0] fpWideType;

  typedef enum logic {StIntegrate, StRefractory} dend_state_e;

  localparam fpWideType SatMax = 40'sd32767;
  localparam fpWideType SatMin = -40'sd32768;

  // Clamp a wide signed value into the 16-bit signed range.
  function automatic fpType sat16(input fpWideType x);
    if (x > SatMax) begin
      sat16 = 16'sh7fff;
    end else if (x < SatMin) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = x[WORD_LENGTH-1:0];
    end
  endfunction

endpackage

// File: rtl/config_if.sv
// One hop of the daisy-chained configuration shift chain.
interface config_if;
  logic        data_clk;
  logic [15:0] data_in;

  modport slave (input data_clk, input data_in);
  modport master (output data_clk, output data_in);
endinterface

// File: rtl/synapse_dendrite_if.sv
// Point-to-point link between one synapse and its dendrite compartment.
interface synapse_dendrite_if;
  import fp::*;

  fpType output_current;
  fpType vmem;

  modport dendrite (input output_current, output vmem);
  modport synapse (output output_current, input vmem);
endinterface

// File: rtl/dendrite_cfg_chain.sv
// Four operating-parameter registers plus the chain output stage, clocked by the config clock.
module dendrite_cfg_chain
  import fp::*;
(
  input  logic        data_clk_i,
  input  logic [15:0] data_i,
  output fpType       e_l_o,
  output logic [15:0] g_leak_o,
  output fpType       v_thresh_o,
  output fpType       v_reset_o,
  output logic [15:0] data_o
);

  fpType       e_l_q;
  logic [15:0] g_leak_q;
  fpType       v_thresh_q;
  fpType       v_reset_q;
  logic [15:0] data_q;

  // Shift one word per config clock; deliberately not reset so a loaded config survives reset.
  always_ff @(posedge data_clk_i) begin
    e_l_q      <= data_i;
    g_leak_q   <= e_l_q;
    v_thresh_q <= g_leak_q;
    v_reset_q  <= v_thresh_q;
    data_q     <= v_reset_q;
  end

  assign e_l_o      = e_l_q;
  assign g_leak_o   = g_leak_q;
  assign v_thresh_o = v_thresh_q;
  assign v_reset_o  = v_reset_q;
  assign data_o     = data_q;

endmodule

// File: rtl/dendrite_compartment.sv
// Leaky integrate-and-fire compartment summing the currents of NUM_SYN synapses.
module dendrite_compartment
  import fp::*;
#(
  parameter int unsigned NUM_SYN    = 4,
  parameter int unsigned LEAK_SHIFT = 8,
  parameter int unsigned DT_SHIFT   = 4,
  parameter int unsigned T_REF      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  synapse_dendrite_if.dendrite        syn [NUM_SYN],
  config_if.slave                     cfg_in,
  config_if.master                    cfg_out,
  output logic                        spike,
  output fpType                       vmem_out
);

  localparam int unsigned SumW = WORD_LENGTH + $clog2(NUM_SYN);
  localparam int unsigned CntW = (T_REF > 0) ? $clog2(T_REF + 1) : 1;

  typedef logic signed [SumW-1:0] sum_t;

  fpType       e_l;
  logic [15:0] g_leak;
  fpType       v_thresh;
  fpType       v_reset;
  logic [15:0] cfg_data_out;

  dendrite_cfg_chain u_cfg_chain (
    .data_clk_i (cfg_in.data_clk),
    .data_i     (cfg_in.data_in),
    .e_l_o      (e_l),
    .g_leak_o   (g_leak),
    .v_thresh_o (v_thresh),
    .v_reset_o  (v_reset),
    .data_o     (cfg_data_out)
  );

  assign cfg_out.data_clk = cfg_in.data_clk;
  assign cfg_out.data_in  = cfg_data_out;

  fpType              vmem_q, vmem_d;
  logic               spike_q, spike_d;
  sum_t               isum_q;
  dend_state_e        state_q, state_d;
  logic [CntW-1:0]    ref_cnt_q, ref_cnt_d;

  // Sign-extended running sum; the extra $clog2(NUM_SYN) bits make overflow impossible.
  sum_t psum [NUM_SYN+1];
  assign psum[0] = '0;

  for (genvar i = 0; i < NUM_SYN; i++) begin : g_syn
    assign psum[i+1]  = psum[i] + sum_t'(syn[i].output_current);
    assign syn[i].vmem = vmem_q;
  end

  // Leak and Euler step, all in a wide signed domain before the final clamp.
  logic signed [16:0] leak_diff;
  logic signed [33:0] leak_prod;
  fpWideType          ileak;
  fpWideType          dv;
  fpType              vmem_next;

  always_comb begin
    leak_diff = {e_l[15], e_l} - {vmem_q[15], vmem_q};
    leak_prod = leak_diff * $signed({1'b0, g_leak});
    ileak     = fpWideType'(leak_prod) >>> LEAK_SHIFT;
    dv        = (fpWideType'(isum_q) + ileak) >>> DT_SHIFT;
    vmem_next = sat16(fpWideType'(vmem_q) + dv);
  end

  // Next-state: integrate, fire-and-reset, or hold through the refractory window.
  always_comb begin
    vmem_d    = vmem_q;
    spike_d   = 1'b0;
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    unique case (state_q)
      StIntegrate: begin
        if (vmem_next >= v_thresh) begin
          spike_d = 1'b1;
          vmem_d  = v_reset;
          if (T_REF > 0) begin
            state_d   = StRefractory;
            ref_cnt_d = CntW'(T_REF);
          end
        end else begin
          vmem_d = vmem_next;
        end
      end
      StRefractory: begin
        vmem_d    = v_reset;
        ref_cnt_d = ref_cnt_q - CntW'(1);
        if (ref_cnt_q == CntW'(1)) begin
          state_d = StIntegrate;
        end
      end
      default: state_d = StIntegrate;
    endcase
  end

  // Membrane state and current pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vmem_q    <= '0;
      spike_q   <= 1'b0;
      isum_q    <= '0;
      state_q   <= StIntegrate;
      ref_cnt_q <= '0;
    end else begin
      vmem_q    <= vmem_d;
      spike_q   <= spike_d;
      isum_q    <= psum[NUM_SYN];
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  assign spike    = spike_q;
  assign vmem_out = vmem_q;

endmodule
